// File: rtl/fr_pkg.sv
// Shared definitions for the frame-pulse generator: FSM state type and default sizing.
package fr_pkg;

  // 50000 clk cycles per tick gives 1 ms at 50 MHz.
  localparam int unsigned CLK_DIV_DEF = 50000;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    GAP  = 2'd2
  } fr_state_e;

endpackage

// File: rtl/fr_tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV enabled clk cycles.
module fr_tick_gen
  import fr_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;

  assign o_tick = i_en && (r_presc == LAST);

  // Count 0..CLK_DIV-1 while enabled; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
    end else if (i_en) begin
      r_presc <= o_tick ? '0 : r_presc + PW'(1);
    end
  end

endmodule

// File: rtl/fr_pulse_gen.sv
// Emulated active-low sensor line: trains of reps+1 low pulses separated by high gaps,
// with phase lengths counted in prescaler ticks.
module fr_pulse_gen
  import fr_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] low_ticks,
  input  logic [CNT_W-1:0] high_ticks,
  input  logic [7:0]       reps,
  output logic             fr_out,
  output logic             busy,
  output logic             done
);

  fr_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_low, w_low_nxt;
  logic [CNT_W-1:0] r_high, w_high_nxt;
  logic [7:0]       r_reps_left, w_reps_left_nxt;
  logic             r_fr_out, w_fr_out_nxt;
  logic             r_done, w_done_nxt;

  logic             w_tick;
  logic             w_presc_clr;
  logic             w_presc_en;
  logic [CNT_W-1:0] w_target;
  logic             w_phase_end;

  // Prescaler idles cleared outside a train so every phase starts on a fresh tick period.
  assign w_presc_en  = (r_state != IDLE);
  assign w_presc_clr = (r_state == IDLE) || abort;

  fr_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_presc_clr),
    .i_en  (w_presc_en),
    .o_tick(w_tick)
  );

  // A zero gap length would never match the counter, so it is stretched to one tick.
  assign w_target = (r_state == GAP) ? ((r_high == '0) ? CNT_W'(1) : r_high) : r_low;

  // Widened compare so counter+1 cannot wrap at the top of the range.
  assign w_phase_end = w_tick &&
                       (({1'b0, r_cnt} + (CNT_W + 1)'(1)) == {1'b0, w_target});

  assign fr_out = r_fr_out;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;

  // Next-state logic; abort overrides start and phase completion.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_low_nxt       = r_low;
    w_high_nxt      = r_high;
    w_reps_left_nxt = r_reps_left;
    w_fr_out_nxt    = r_fr_out;
    w_done_nxt      = 1'b0;

    if (abort) begin
      w_state_nxt     = IDLE;
      w_cnt_nxt       = '0;
      w_reps_left_nxt = '0;
      w_fr_out_nxt    = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (low_ticks != '0) begin
              w_low_nxt       = low_ticks;
              w_high_nxt      = high_ticks;
              w_reps_left_nxt = reps;
              w_cnt_nxt       = '0;
              w_fr_out_nxt    = 1'b0;
              w_state_nxt     = LOW;
            end else begin
              // Empty train: report completion without touching the line.
              w_done_nxt = 1'b1;
            end
          end
        end
        LOW: begin
          if (w_phase_end) begin
            w_cnt_nxt    = '0;
            w_fr_out_nxt = 1'b1;
            if (r_reps_left == '0) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_reps_left_nxt = r_reps_left - 8'd1;
              w_state_nxt     = GAP;
            end
          end else if (w_tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (w_phase_end) begin
            w_cnt_nxt    = '0;
            w_fr_out_nxt = 1'b0;
            w_state_nxt  = LOW;
          end else if (w_tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_fr_out_nxt = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset drives the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_low       <= '0;
      r_high      <= '0;
      r_reps_left <= '0;
      r_fr_out    <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_low       <= w_low_nxt;
      r_high      <= w_high_nxt;
      r_reps_left <= w_reps_left_nxt;
      r_fr_out    <= w_fr_out_nxt;
      r_done      <= w_done_nxt;
    end
  end

endmodule
